// File: rtl/fft_bitrev_reorder.sv
// fft_bitrev_reorder: ping-pong buffer restoring natural order to bit-reversed FFT frames
module fft_bitrev_reorder #(
    parameter int DATA_WIDTH = 16,
    parameter int N_POINTS   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_val,
    output logic                  in_ready,
    input  logic                  in_last,
    input  logic [DATA_WIDTH-1:0] in_re,
    input  logic [DATA_WIDTH-1:0] in_im,
    output logic                  out_val,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic [DATA_WIDTH-1:0] out_re,
    output logic [DATA_WIDTH-1:0] out_im,
    output logic                  frame_err
);
    localparam int LOG2N_BITS = $clog2(N_POINTS);
    localparam logic [LOG2N_BITS-1:0] LAST = LOG2N_BITS'(N_POINTS - 1);

    logic [DATA_WIDTH-1:0] mem_re_q [2][N_POINTS];
    logic [DATA_WIDTH-1:0] mem_im_q [2][N_POINTS];
    logic [LOG2N_BITS-1:0] wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d, rd_idx;
    logic                  wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
    logic [1:0]            full_q, full_d;
    logic                  out_val_q, out_val_d, out_last_q, out_last_d;
    logic                  frame_err_q, frame_err_d;
    logic [DATA_WIDTH-1:0] out_re_q, out_re_d, out_im_q, out_im_d;
    logic                  wr_en, wr_end, rd_en, rd_end;

    assign in_ready  = !full_q[wr_bank_q];
    assign out_val   = out_val_q;
    assign out_last  = out_last_q;
    assign out_re    = out_re_q;
    assign out_im    = out_im_q;
    assign frame_err = frame_err_q;

    // read address is the bit-reversed read counter
    always_comb begin
        rd_idx = '0;
        for (int j = 0; j < LOG2N_BITS; j++) rd_idx[LOG2N_BITS-1-j] = rd_cnt_q[j];
    end

    // next-state: write/read handshakes, bank flags and output register
    always_comb begin
        wr_en       = in_val && in_ready;
        wr_end      = wr_en && (wr_cnt_q == LAST);
        rd_en       = full_q[rd_bank_q] && (!out_val_q || out_ready);
        rd_end      = rd_en && (rd_cnt_q == LAST);
        wr_cnt_d    = wr_en ? wr_cnt_q + 1'b1 : wr_cnt_q;
        rd_cnt_d    = rd_en ? rd_cnt_q + 1'b1 : rd_cnt_q;
        wr_bank_d   = wr_bank_q ^ wr_end;
        rd_bank_d   = rd_bank_q ^ rd_end;
        full_d      = full_q;
        if (wr_end) full_d[wr_bank_q] = 1'b1;
        if (rd_end) full_d[rd_bank_q] = 1'b0;
        out_val_d   = rd_en ? 1'b1 : (out_ready ? 1'b0 : out_val_q);
        out_last_d  = rd_en ? (rd_cnt_q == LAST) : (out_ready ? 1'b0 : out_last_q);
        out_re_d    = rd_en ? mem_re_q[rd_bank_q][rd_idx] : out_re_q;
        out_im_d    = rd_en ? mem_im_q[rd_bank_q][rd_idx] : out_im_q;
        frame_err_d = frame_err_q || (wr_en && (in_last != (wr_cnt_q == LAST)));
    end

    // sample storage; only ever written in an EMPTY bank, so no read collision
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_re_q[wr_bank_q][wr_cnt_q] <= in_re;
            mem_im_q[wr_bank_q][wr_cnt_q] <= in_im;
        end
    end

    // control and output state; reset discards any partial or pending frames
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_cnt_q    <= '0;
            rd_cnt_q    <= '0;
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
            full_q      <= '0;
            out_val_q   <= 1'b0;
            out_last_q  <= 1'b0;
            out_re_q    <= '0;
            out_im_q    <= '0;
            frame_err_q <= 1'b0;
        end else begin
            wr_cnt_q    <= wr_cnt_d;
            rd_cnt_q    <= rd_cnt_d;
            wr_bank_q   <= wr_bank_d;
            rd_bank_q   <= rd_bank_d;
            full_q      <= full_d;
            out_val_q   <= out_val_d;
            out_last_q  <= out_last_d;
            out_re_q    <= out_re_d;
            out_im_q    <= out_im_d;
            frame_err_q <= frame_err_d;
        end
    end
endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// tb_fft_bitrev_reorder: scoreboard bench for the bit-reverse reorder buffer
module tb_fft_bitrev_reorder;
    localparam int DW = 16;
    localparam int N  = 16;

    logic          clk = 1'b0, rst = 1'b1;
    logic          in_val = 1'b0, in_last = 1'b0, out_ready = 1'b0;
    logic [DW-1:0] in_re = '0, in_im = '0;
    logic          in_ready, out_val, out_last, frame_err;
    logic [DW-1:0] out_re, out_im;

    fft_bitrev_reorder #(.DATA_WIDTH(DW), .N_POINTS(N)) dut (
        .clk(clk), .rst(rst), .in_val(in_val), .in_ready(in_ready), .in_last(in_last),
        .in_re(in_re), .in_im(in_im), .out_val(out_val), .out_ready(out_ready),
        .out_last(out_last), .out_re(out_re), .out_im(out_im), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] re;
        logic [DW-1:0] im;
        logic          last;
    } exp_t;

    exp_t q[$];
    int   total = 0, bad = 0, acc_cnt = 0, out_cnt = 0, bubbles = 0;
    logic rnd_ready = 1'b0;

    function automatic logic [3:0] br(input int k);
        logic [3:0] v;
        v = 4'(k);
        return {v[0], v[1], v[2], v[3]};
    endfunction

    function automatic logic [DW-1:0] mk(input int f, input int k);
        return DW'((f % 256) * 256 + k);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    // monitor: pops expected sample on each output transfer, checks hold under stall
    initial begin
        exp_t        e;
        logic        hold_p, prev_val;
        logic [32:0] held;
        hold_p = 1'b0;
        prev_val = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                hold_p = 1'b0;
                prev_val = 1'b0;
            end else begin
                if (hold_p) chk("hold", {out_val, out_re, out_im, out_last}, {1'b1, held});
                hold_p = out_val && !out_ready;
                held = {out_re, out_im, out_last};
                if (out_val && out_ready) begin
                    out_cnt++;
                    if (q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_out: got re=%0h with nothing expected", out_re);
                    end else begin
                        e = q.pop_front();
                        chk("out", {out_re, out_im, out_last}, {e.re, e.im, e.last});
                    end
                end
                if (in_val && in_ready) acc_cnt++;
                if (!out_val && out_ready && prev_val && q.size() > 0) bubbles++;
                prev_val = out_val;
            end
        end
    end

    // random downstream readiness when enabled
    initial forever begin
        @(posedge clk);
        #1;
        if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
    end

    task automatic send_frame(input int f, input int gap, input int err_at, input int n, output int waits);
        exp_t e;
        logic ok;
        int   tries;
        waits = 0;
        for (int k = 0; k < N; k++) begin
            e.re = mk(f, k);
            e.im = -mk(f, k);
            e.last = (k == N - 1);
            q.push_back(e);
        end
        for (int i = 0; i < n; i++) begin
            if (gap > 0) repeat ($urandom_range(0, gap)) begin
                in_val = 1'b0;
                @(posedge clk);
                #1;
            end
            in_val  = 1'b1;
            in_re   = mk(f, int'(br(i)));
            in_im   = -mk(f, int'(br(i)));
            in_last = (i == N - 1) || (i == err_at);
            tries = 0;
            do begin
                @(negedge clk);
                ok = in_ready;
                @(posedge clk);
                #1;
                if (!ok) waits++;
                tries++;
            end while (!ok && tries < 500);
            if (!ok) begin
                $display("FAIL send_timeout: frame %0d sample %0d never accepted", f, i);
                $fatal(1);
            end
            if (err_at >= 0) chk("frame_err_mid", frame_err, i >= err_at);
        end
        in_val  = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (q.size() > 0 && t < 3000) begin
            @(posedge clk);
            t++;
        end
        chk("drain_left", q.size(), 0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        int w, ws, a0, o0, b0;
        #12;
        chk("rst_out_val", out_val, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_out_re", out_re, 0);
        chk("rst_out_im", out_im, 0);
        chk("rst_frame_err", frame_err, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1);

        // single frame, latency and natural order
        out_ready = 1'b1;
        send_frame(0, 0, -1, N, w);
        chk("lat_not_yet", out_val, 0);
        @(posedge clk);
        #1;
        chk("lat_val", out_val, 1);
        chk("lat_idx0", out_re, 0);
        chk("single_frame_err", frame_err, 0);
        drain();

        // four back-to-back frames at full rate
        o0 = out_cnt;
        b0 = bubbles;
        ws = 0;
        for (int f = 1; f <= 4; f++) begin
            send_frame(f, 0, -1, N, w);
            ws += w;
        end
        drain();
        chk("b2b_waits", ws, 0);
        chk("b2b_count", out_cnt - o0, 64);
        chk("b2b_bubbles", bubbles - b0, 0);

        // backpressure: both banks fill, input stalls
        out_ready = 1'b0;
        a0 = acc_cnt;
        o0 = out_cnt;
        fork
            for (int f = 5; f <= 7; f++) send_frame(f, 0, -1, N, w);
            begin
                repeat (40) @(posedge clk);
                #3;
                chk("bp_accepts", acc_cnt - a0, 32);
                chk("bp_in_ready", in_ready, 0);
                out_ready = 1'b1;
            end
        join
        drain();
        chk("bp_count", out_cnt - o0, 48);

        // random gaps and random readiness
        o0 = out_cnt;
        rnd_ready = 1'b1;
        for (int f = 8; f < 18; f++) send_frame(f, 2, -1, N, w);
        @(negedge clk);
        rnd_ready = 1'b0;
        @(posedge clk);
        #2;
        out_ready = 1'b1;
        drain();
        chk("rand_count", out_cnt - o0, 160);

        // early in_last sets sticky error, data unaffected
        send_frame(18, 0, 6, N, w);
        drain();
        chk("frame_err_sticky", frame_err, 1);

        // reset mid-frame while previous frame is half read
        send_frame(19, 0, -1, N, w);
        send_frame(20, 0, -1, 9, w);
        rst = 1'b1;
        #1;
        chk("mid_rst_val", out_val, 0);
        chk("mid_rst_re", {out_re, out_im, out_last}, 0);
        chk("mid_rst_err", frame_err, 0);
        q.delete();
        @(negedge clk);
        rst = 1'b0;
        o0 = out_cnt;
        repeat (5) @(posedge clk);
        #1;
        chk("post_rst_idle", out_val, 0);
        send_frame(21, 0, -1, N, w);
        drain();
        chk("post_rst_count", out_cnt - o0, 16);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
endmodule
